// File: rtl/bank_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
package bank_arb_pkg;

  // Default bank geometry: 32 entries of 32-bit words
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;

  // Requester tags, also used as bit positions in request/grant pairs
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Sequencer states: wait for a request, drive the bank, present the response
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/bank_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// side the pointer names, and the pointer then moves to the losing side.
module rr_arb2
  import bank_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_next
);

  // Pick the winner and the pointer value that follows the grant
  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr;
    if (req[REQ_A] && (!req[REQ_B] || (ptr == REQ_A))) begin
      gnt[REQ_A] = 1'b1;
      ptr_next   = REQ_B;
    end else if (req[REQ_B]) begin
      gnt[REQ_B] = 1'b1;
      ptr_next   = REQ_A;
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Serialises two clients onto one register-bank port set. A grant latches the
// winner's fields, the next cycle drives the bank, and the cycle after that
// presents registered read data with a valid strobe for the winner.
module bank_arbiter
  import bank_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic [AW-1:0] ra1_a,
  input  logic [AW-1:0] ra2_a,
  input  logic [AW-1:0] wa_a,
  input  logic [DW-1:0] din_a,
  input  logic          we_a,
  input  logic          req_b,
  input  logic [AW-1:0] ra1_b,
  input  logic [AW-1:0] ra2_b,
  input  logic [AW-1:0] wa_b,
  input  logic [DW-1:0] din_b,
  input  logic          we_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rsp_valid_a,
  output logic          rsp_valid_b,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          busy,
  output logic [AW-1:0] bank_ra1,
  output logic [AW-1:0] bank_ra2,
  output logic [AW-1:0] bank_wa,
  output logic [DW-1:0] bank_din,
  output logic          bank_rw,
  input  logic [DW-1:0] bank_dr1,
  input  logic [DW-1:0] bank_dr2
);

  state_t        state;
  logic          ptr;
  logic [AW-1:0] ra1_q, ra2_q, wa_q;
  logic [DW-1:0] din_q;
  logic          we_q;
  logic          tag_q;

  logic [1:0]    arb_gnt;
  logic          ptr_next;
  logic          can_grant;
  logic          fwd1, fwd2;

  rr_arb2 u_rr_arb2 (
    .req      ({req_b, req_a}),
    .ptr      (ptr),
    .gnt      (arb_gnt),
    .ptr_next (ptr_next)
  );

  // Grants are only offered while the port set is free for a new issue;
  // gating with rst_n keeps them low for the whole reset pulse.
  assign can_grant = rst_n && (state != ISSUE);
  assign gnt_a     = can_grant && arb_gnt[REQ_A];
  assign gnt_b     = can_grant && arb_gnt[REQ_B];
  assign busy      = (state != IDLE);

  // A write to a register that is also being read returns the new data
  assign fwd1 = we_q && (ra1_q == wa_q);
  assign fwd2 = we_q && (ra2_q == wa_q);

  // Drive the bank from the latched fields only during the issue cycle
  always_comb begin
    bank_ra1 = '0;
    bank_ra2 = '0;
    bank_wa  = '0;
    bank_din = '0;
    bank_rw  = 1'b0;
    if (state == ISSUE) begin
      bank_ra1 = ra1_q;
      bank_ra2 = ra2_q;
      bank_wa  = wa_q;
      bank_din = din_q;
      bank_rw  = we_q;
    end
  end

  // Sequencer: grant/latch, bank access and read-data capture, response strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= REQ_A;
      ra1_q       <= '0;
      ra2_q       <= '0;
      wa_q        <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      tag_q       <= REQ_A;
      rdata1      <= '0;
      rdata2      <= '0;
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
    end else begin
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (|arb_gnt) begin
            ra1_q <= arb_gnt[REQ_B] ? ra1_b : ra1_a;
            ra2_q <= arb_gnt[REQ_B] ? ra2_b : ra2_a;
            wa_q  <= arb_gnt[REQ_B] ? wa_b  : wa_a;
            din_q <= arb_gnt[REQ_B] ? din_b : din_a;
            we_q  <= arb_gnt[REQ_B] ? we_b  : we_a;
            tag_q <= arb_gnt[REQ_B] ? REQ_B : REQ_A;
            ptr   <= ptr_next;
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          rdata1      <= fwd1 ? din_q : bank_dr1;
          rdata2      <= fwd2 ? din_q : bank_dr2;
          rsp_valid_a <= (tag_q == REQ_A);
          rsp_valid_b <= (tag_q == REQ_B);
          state       <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Randomised bench for bank_arbiter with a register-bank model and a
// transaction-level reference of the arbitration and read/write rules.
module tb_bank_arbiter;
  import bank_arb_pkg::*;

  localparam int DW = DEF_DW;
  localparam int AW = DEF_AW;

  typedef struct {
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic [DW-1:0] din;
    logic          we;
  } txn_t;

  typedef struct {
    int            due;
    logic          tag;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  txn_t          cur_a, cur_b;
  logic          gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, busy, bank_rw;
  logic [DW-1:0] rdata1, rdata2, bank_din, bank_dr1, bank_dr2;
  logic [AW-1:0] bank_ra1, bank_ra2, bank_wa;

  bank_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .ra1_a(cur_a.ra1), .ra2_a(cur_a.ra2), .wa_a(cur_a.wa),
    .din_a(cur_a.din), .we_a(cur_a.we),
    .req_b(req_b), .ra1_b(cur_b.ra1), .ra2_b(cur_b.ra2), .wa_b(cur_b.wa),
    .din_b(cur_b.din), .we_b(cur_b.we),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
    .rdata1(rdata1), .rdata2(rdata2), .busy(busy),
    .bank_ra1(bank_ra1), .bank_ra2(bank_ra2), .bank_wa(bank_wa),
    .bank_din(bank_din), .bank_rw(bank_rw),
    .bank_dr1(bank_dr1), .bank_dr2(bank_dr2)
  );

  always #5 clk = ~clk;

  // Register bank: combinational reads, clocked write, preloaded once
  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 3) return 32'd100;
    if (i == 5) return 32'd752;
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  logic          bank_load = 1'b1;
  logic [DW-1:0] bank_mem [32];
  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 32; i++) bank_mem[i] <= init_val(i);
    end else if (bank_rw) begin
      bank_mem[bank_wa] <= bank_din;
    end
  end
  assign bank_dr1 = bank_mem[bank_ra1];
  assign bank_dr2 = bank_mem[bank_ra2];

  // Reference state
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            last_grant = -100;
  int            n_txn = 0;
  logic          ptr_m = REQ_A;
  txn_t          last_txn;
  logic [DW-1:0] shadow [32];
  rsp_t          expq [$];
  txn_t          q_a [$];
  txn_t          q_b [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input int ra1, input int ra2, input int wa,
                              input logic [DW-1:0] din, input logic we);
    txn_t t;
    t.ra1 = 5'(ra1); t.ra2 = 5'(ra2); t.wa = 5'(wa); t.din = din; t.we = we;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.wa  = 5'($urandom_range(0, 31));
    t.ra1 = 5'($urandom_range(0, 31));
    t.ra2 = 5'($urandom_range(0, 31));
    t.din = $urandom;
    t.we  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) t.ra1 = t.wa;
    if ($urandom_range(0, 3) == 0) t.ra2 = t.wa;
    return t;
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_gnt_a", 32'(gnt_a), 32'd0);
    check_eq("rst_gnt_b", 32'(gnt_b), 32'd0);
    check_eq("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check_eq("rst_rsp_valid_b", 32'(rsp_valid_b), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_bank_rw", 32'(bank_rw), 32'd0);
    check_eq("rst_bank_ra1", 32'(bank_ra1), 32'd0);
    check_eq("rst_bank_ra2", 32'(bank_ra2), 32'd0);
    check_eq("rst_bank_wa", 32'(bank_wa), 32'd0);
    check_eq("rst_bank_din", bank_din, 32'd0);
    check_eq("rst_rdata1", rdata1, 32'd0);
    check_eq("rst_rdata2", rdata2, 32'd0);
  endtask

  // Predict and compare one cycle; returns the grants the rules call for
  task automatic eval_cycle(output logic ga, output logic gb);
    logic allow, issue, exp_va, exp_vb;
    rsp_t r;
    txn_t t;
    allow = (cyc - last_grant) >= 2;
    issue = (cyc == last_grant + 1);
    ga = allow && req_a && (!req_b || ptr_m == REQ_A);
    gb = allow && req_b && (!req_a || ptr_m == REQ_B);
    check_eq("gnt_a", 32'(gnt_a), 32'(ga));
    check_eq("gnt_b", 32'(gnt_b), 32'(gb));
    check_eq("busy", 32'(busy), 32'(issue || (cyc == last_grant + 2)));
    check_eq("bank_rw", 32'(bank_rw), 32'(issue && last_txn.we));
    check_eq("bank_ra1", 32'(bank_ra1), issue ? 32'(last_txn.ra1) : 32'd0);
    check_eq("bank_ra2", 32'(bank_ra2), issue ? 32'(last_txn.ra2) : 32'd0);
    check_eq("bank_wa", 32'(bank_wa), issue ? 32'(last_txn.wa) : 32'd0);
    check_eq("bank_din", bank_din, issue ? last_txn.din : 32'd0);
    exp_va = 1'b0;
    exp_vb = 1'b0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      r = expq.pop_front();
      exp_va = (r.tag == REQ_A);
      exp_vb = (r.tag == REQ_B);
      check_eq("rdata1", rdata1, r.d1);
      check_eq("rdata2", rdata2, r.d2);
      n_txn++;
      $display("txn %0d cycle %0d: requester %s rdata1=%h rdata2=%h",
               n_txn, cyc, (r.tag == REQ_A) ? "A" : "B", rdata1, rdata2);
    end
    check_eq("rsp_valid_a", 32'(rsp_valid_a), 32'(exp_va));
    check_eq("rsp_valid_b", 32'(rsp_valid_b), 32'(exp_vb));
    if (ga || gb) begin
      t      = ga ? cur_a : cur_b;
      r.due  = cyc + 2;
      r.tag  = ga ? REQ_A : REQ_B;
      r.d1   = (t.we && t.ra1 == t.wa) ? t.din : shadow[t.ra1];
      r.d2   = (t.we && t.ra2 == t.wa) ? t.din : shadow[t.ra2];
      if (t.we) shadow[t.wa] = t.din;
      expq.push_back(r);
      last_grant = cyc;
      last_txn   = t;
      ptr_m      = ga ? REQ_B : REQ_A;
    end
  endtask

  // Requesters: drop req after a grant, occasionally withdraw an ungranted one
  task automatic drive(input logic ga, input logic gb, input int rate, input bit allow_drop);
    bit dropped;
    dropped = 1'b0;
    if (ga) req_a = 1'b0;
    else if (req_a && allow_drop && $urandom_range(0, 9) == 0) begin
      req_a = 1'b0; q_a.push_front(cur_a); dropped = 1'b1;
    end
    if (!req_a && !dropped && q_a.size() > 0 && int'($urandom_range(0, 99)) < rate) begin
      cur_a = q_a.pop_front(); req_a = 1'b1;
    end
    dropped = 1'b0;
    if (gb) req_b = 1'b0;
    else if (req_b && allow_drop && $urandom_range(0, 9) == 0) begin
      req_b = 1'b0; q_b.push_front(cur_b); dropped = 1'b1;
    end
    if (!req_b && !dropped && q_b.size() > 0 && int'($urandom_range(0, 99)) < rate) begin
      cur_b = q_b.pop_front(); req_b = 1'b1;
    end
  endtask

  task automatic cycle(input int rate, input bit allow_drop);
    logic ga, gb;
    @(negedge clk);
    eval_cycle(ga, gb);
    @(posedge clk);
    #1;
    cyc++;
    drive(ga, gb, rate, allow_drop);
  endtask

  task automatic run_phase(input int rate, input bit allow_drop);
    int budget;
    budget = 0;
    drive(1'b0, 1'b0, rate, 1'b0);
    while ((q_a.size() > 0 || q_b.size() > 0 || req_a || req_b || expq.size() > 0)
           && budget < 5000) begin
      cycle(rate, allow_drop);
      budget++;
    end
    check_eq("drain_timeout", 32'(budget < 5000), 32'd1);
  endtask

  // Called just after a rising edge; reset checks are immediate (asynchronous)
  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    #1;
    check_reset_outputs();
    expq.delete();
    last_grant = -100;
    ptr_m      = REQ_A;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    cur_a = mk(0, 0, 0, 32'd0, 1'b0);
    cur_b = mk(0, 0, 0, 32'd0, 1'b0);
    last_txn = cur_a;
    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1;
    bank_load = 1'b0;
    check_reset_outputs();
    rst_n = 1'b1;

    // Single read by A from registers 3 and 5
    q_a.push_back(mk(3, 5, 0, 32'd0, 1'b0));
    run_phase(100, 1'b0);

    // Simultaneous requests right after reset: A wins first
    do_reset();
    q_a.push_back(mk(1, 2, 0, 32'd0, 1'b0));
    q_b.push_back(mk(4, 6, 0, 32'd0, 1'b0));
    run_phase(100, 1'b0);

    // Both hold requests for four transactions: strict alternation
    q_a.push_back(mk(8, 9, 0, 32'd0, 1'b0));
    q_a.push_back(mk(10, 11, 0, 32'd0, 1'b0));
    q_b.push_back(mk(12, 13, 0, 32'd0, 1'b0));
    q_b.push_back(mk(14, 15, 0, 32'd0, 1'b0));
    run_phase(100, 1'b0);

    // B writes register 7 with write-first read-back, then A reads it
    q_b.push_back(mk(7, 2, 7, 32'hDEAD, 1'b1));
    run_phase(100, 1'b0);
    q_a.push_back(mk(7, 7, 0, 32'd0, 1'b0));
    run_phase(100, 1'b0);

    // B alone, back to back
    for (int i = 0; i < 3; i++) q_b.push_back(rand_txn());
    run_phase(100, 1'b0);

    // Randomised traffic with gaps and withdrawn requests
    for (int i = 0; i < 150; i++) begin
      q_a.push_back(rand_txn());
      q_b.push_back(rand_txn());
    end
    run_phase(70, 1'b1);

    // Reset while a read is in its bank-access cycle
    q_a.push_back(mk(9, 10, 0, 32'd0, 1'b0));
    drive(1'b0, 1'b0, 100, 1'b0);
    guard = 0;
    while (last_grant != cyc - 1 && guard < 10) begin
      cycle(100, 1'b0);
      guard++;
    end
    check_eq("issue_reached", 32'(busy), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(100, 1'b0);
    q_a.push_back(mk(3, 7, 0, 32'd0, 1'b0));
    q_b.push_back(mk(5, 7, 0, 32'd0, 1'b0));
    run_phase(100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bank_arbiter.md
# bank_arbiter

Two-requester arbiter and sequencer for the 32 x 32-bit register bank (two combinational read ports, one write port). It sits between the register bank and two clients, requester A (execute writeback path) and requester B (load/debug path). It serialises their read/write transactions onto the bank's single port set with round-robin fairness. It returns registered read data with a fixed latency and a valid strobe tagged to the requester.

## Interface
- DW, 32, data width (matches bank word)
- AW, 5, register address width (32 entries)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_a / req_b  in  1  transaction request; held high with fields stable until gnt
- ra1_a, ra2_a / ra1_b, ra2_b  in  AW  read addresses
- wa_a / wa_b  in  AW  write address
- din_a / din_b  in  DW  write data
- we_a / we_b  in  1  transaction includes a write
- gnt_a / gnt_b  out  1  request accepted this cycle (combinational, one-hot or zero)
- rsp_valid_a / rsp_valid_b  out  1  one-cycle strobe, read data valid
- rdata1, rdata2  out  DW  read data for the strobed requester
- busy  out  1  a transaction is in ISSUE or RESP
- bank_ra1, bank_ra2, bank_wa  out  AW  drive bank read/write addresses
- bank_din  out  DW  drive bank write data
- bank_rw  out  1  bank write enable
- bank_dr1, bank_dr2  in  DW  bank read data

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req, grant a winner. Latch its ra1/ra2/wa/din/we and tag on the edge, then go to ISSUE. With no req, stay in IDLE.
- ISSUE: drive bank_* from latched fields; bank_rw = latched we. Capture bank_dr1/dr2 into rdata1/rdata2 on the edge, then go to RESP.
- RESP: assert rsp_valid for the tagged requester. A new grant may be issued in RESP (same rules as IDLE), which goes to ISSUE; otherwise go to IDLE.
- Arbitration: a 1-bit round-robin pointer sets priority. Only one requester active -> it wins regardless of pointer. Both active -> the pointer's side wins. After every grant, the pointer points to the non-granted side.
- Write-first: a transaction with we=1 and ra1 or ra2 equal to wa returns the new din on that port.
- Outside ISSUE: bank_rw=0 and bank_ra1/ra2/wa/din=0.
- rdata1/rdata2 hold their last value until the next capture.

## Timing
- Grant in cycle N -> bank access in N+1 -> rsp_valid and data in N+2.
- Peak throughput is one transaction per 2 cycles, since grants occur only in IDLE or RESP.
- gnt is never asserted in ISSUE; requesters keep req high and fields stable until gnt.
- req dropped before gnt: no transaction occurs, no state change.
- Reset (async, any state) forces:
  - state IDLE, pointer to A, busy=0;
  - all gnt, rsp_valid, bank_rw = 0;
  - all address and data outputs = 0.
- A transaction interrupted by reset never produces a rsp_valid.
- A bank write already applied in ISSUE before reset is not undone.
- rsp_valid_a and rsp_valid_b are never high together.

## Structure
- Package bank_arb_pkg holds:
  - state enum (IDLE, ISSUE, RESP);
  - DW/AW default constants;
  - requester-tag constants (REQ_A=0, REQ_B=1).
- Sub-module rr_arb2 holds the 2-way round-robin picker (inputs: req pair, pointer; outputs: one-hot grant, next pointer).
- The FSM, latch and response registers live in bank_arbiter.

## Test plan
- After reset, A requests ra1=3, ra2=5, we=0 -> gnt_a at N; rsp_valid_a at N+2 with rdata1=100, rdata2=752; bank_rw stays 0.
- A and B request together right after reset -> gnt_a first, then gnt_b two cycles later; responses are tagged A then B.
- Both hold req for 4 transactions -> grant order A,B,A,B at cycles 0,2,4,6; no grant in ISSUE cycles.
- B alone issues we=1, wa=7, din=32'hDEAD, ra1=7 -> bank_rw high only in the ISSUE cycle; rdata1=32'hDEAD. A later read of register 7 by A returns 32'hDEAD.
- B alone issues 3 back-to-back transactions -> B is granted at every opportunity despite pointer rotation.
- rst_n asserted during ISSUE -> all outputs 0 immediately, no rsp_valid afterward; after release, A request is granted first.
